// File: rtl/countdown_timer_mmss.sv
// Settable MM:SS BCD countdown timer driven by an external 1 Hz strobe.
// Raises a one-cycle done pulse and a held expired level at 00:00.
module countdown_timer_mmss #(
  parameter int MAX_MIN_TENS = 5,
  parameter int MAX_SEC_TENS = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic [2:0] load_min_tens,
  input  logic [3:0] load_min_ones,
  input  logic [2:0] load_sec_tens,
  input  logic [3:0] load_sec_ones,
  input  logic       start,
  input  logic       pause,
  output logic [2:0] min_tens,
  output logic [3:0] min_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       done,
  output logic       expired
);

  localparam logic [2:0] MT_MAX = 3'(MAX_MIN_TENS);
  localparam logic [2:0] ST_MAX = 3'(MAX_SEC_TENS);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    EXPIRED
  } state_t;

  state_t state;

  logic [2:0] c_mt;
  logic [3:0] c_mo;
  logic [2:0] c_st;
  logic [3:0] c_so;

  logic [2:0] d_mt;
  logic [3:0] d_mo;
  logic [2:0] d_st;
  logic [3:0] d_so;

  logic cur_zero;
  logic dec_zero;
  logic go;
  logic hold;

  assign cur_zero = (min_tens == 3'd0) && (min_ones == 4'd0)
                 && (sec_tens == 3'd0) && (sec_ones == 4'd0);

  assign dec_zero = (d_mt == 3'd0) && (d_mo == 4'd0)
                 && (d_st == 3'd0) && (d_so == 4'd0);

  // start alone / pause alone; both together is a no-op
  assign go   = start && !pause;
  assign hold = pause && !start;

  // Clamp load digits into legal BCD range
  always_comb begin
    c_mt = load_min_tens;
    c_mo = load_min_ones;
    c_st = load_sec_tens;
    c_so = load_sec_ones;
    if (load_min_tens > MT_MAX) c_mt = MT_MAX;
    if (load_min_ones > 4'd9)   c_mo = 4'd9;
    if (load_sec_tens > ST_MAX) c_st = ST_MAX;
    if (load_sec_ones > 4'd9)   c_so = 4'd9;
  end

  // One-second BCD borrow chain; 00:00 holds
  always_comb begin
    d_mt = min_tens;
    d_mo = min_ones;
    d_st = sec_tens;
    d_so = sec_ones;
    if (cur_zero) begin
      d_so = sec_ones;
    end else if (sec_ones != 4'd0) begin
      d_so = sec_ones - 4'd1;
    end else begin
      d_so = 4'd9;
      if (sec_tens != 3'd0) begin
        d_st = sec_tens - 3'd1;
      end else begin
        d_st = ST_MAX;
        if (min_ones != 4'd0) begin
          d_mo = min_ones - 4'd1;
        end else begin
          d_mo = 4'd9;
          d_mt = min_tens - 3'd1;
        end
      end
    end
  end

  // Control FSM with registered digits and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      min_tens <= 3'd0;
      min_ones <= 4'd0;
      sec_tens <= 3'd0;
      sec_ones <= 4'd0;
      running  <= 1'b0;
      done     <= 1'b0;
      expired  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        min_tens <= c_mt;
        min_ones <= c_mo;
        sec_tens <= c_st;
        sec_ones <= c_so;
        state    <= IDLE;
        running  <= 1'b0;
        expired  <= 1'b0;
      end else if (start || pause) begin
        if (go) begin
          unique case (state)
            IDLE: begin
              if (cur_zero) begin
                state   <= EXPIRED;
                expired <= 1'b1;
                done    <= 1'b1;
              end else begin
                state   <= RUN;
                running <= 1'b1;
              end
            end
            PAUSED: begin
              state   <= RUN;
              running <= 1'b1;
            end
            default: begin
              state <= state;
            end
          endcase
        end else if (hold && state == RUN) begin
          state   <= PAUSED;
          running <= 1'b0;
        end
      end else if (tick && state == RUN) begin
        min_tens <= d_mt;
        min_ones <= d_mo;
        sec_tens <= d_st;
        sec_ones <= d_so;
        if (dec_zero) begin
          state   <= EXPIRED;
          running <= 1'b0;
          expired <= 1'b1;
          done    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer_mmss.sv
// Scoreboard bench for countdown_timer_mmss.
// A seconds-count model predicts every cycle's outputs.
module tb_countdown_timer_mmss;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       load;
  logic [2:0] load_min_tens;
  logic [3:0] load_min_ones;
  logic [2:0] load_sec_tens;
  logic [3:0] load_sec_ones;
  logic       start;
  logic       pause;
  logic [2:0] min_tens;
  logic [3:0] min_ones;
  logic [2:0] sec_tens;
  logic [3:0] sec_ones;
  logic       running;
  logic       done;
  logic       expired;

  always #5 clk = ~clk;

  countdown_timer_mmss dut (
    .clk           (clk),
    .reset         (reset),
    .tick          (tick),
    .load          (load),
    .load_min_tens (load_min_tens),
    .load_min_ones (load_min_ones),
    .load_sec_tens (load_sec_tens),
    .load_sec_ones (load_sec_ones),
    .start         (start),
    .pause         (pause),
    .min_tens      (min_tens),
    .min_ones      (min_ones),
    .sec_tens      (sec_tens),
    .sec_ones      (sec_ones),
    .running       (running),
    .done          (done),
    .expired       (expired)
  );

  typedef struct packed {
    logic [2:0] mt;
    logic [3:0] mo;
    logic [2:0] st;
    logic [3:0] so;
    logic       run;
    logic       dn;
    logic       exp;
  } obs_t;

  obs_t  sbq[$];
  int    vectors = 0;
  int    miscompares = 0;
  string phase = "init";

  // model: 0 idle, 1 run, 2 paused, 3 expired
  int   m_total = 0;
  int   m_st = 0;
  logic m_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s [%s]: got %0h expected %0h",
               tag, phase, got, exp);
    end
  endtask

  function automatic obs_t predict();
    obs_t o;
    int mins;
    int secs;
    mins  = m_total / 60;
    secs  = m_total % 60;
    o.mt  = 3'(mins / 10);
    o.mo  = 4'(mins % 10);
    o.st  = 3'(secs / 10);
    o.so  = 4'(secs % 10);
    o.run = (m_st == 1);
    o.dn  = m_done;
    o.exp = (m_st == 3);
    return o;
  endfunction

  function automatic int clampv(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic cyc(input logic r, input logic l, input logic [13:0] ld,
                     input logic s, input logic p, input logic t);
    int mt;
    int mo;
    int st;
    int so;
    @(negedge clk);
    reset = r;
    load  = l;
    {load_min_tens, load_min_ones, load_sec_tens, load_sec_ones} = ld;
    start = s;
    pause = p;
    tick  = t;
    if (r) begin
      m_total = 0;
      m_st    = 0;
      m_done  = 1'b0;
    end else begin
      m_done = 1'b0;
      if (l) begin
        mt = clampv(int'(ld[13:11]), 5);
        mo = clampv(int'(ld[10:7]), 9);
        st = clampv(int'(ld[6:4]), 5);
        so = clampv(int'(ld[3:0]), 9);
        m_total = (mt * 10 + mo) * 60 + st * 10 + so;
        m_st    = 0;
      end else if (s && !p) begin
        if (m_st == 0) begin
          if (m_total == 0) begin
            m_st   = 3;
            m_done = 1'b1;
          end else begin
            m_st = 1;
          end
        end else if (m_st == 2) begin
          m_st = 1;
        end
      end else if (p && !s) begin
        if (m_st == 1) m_st = 2;
      end else if (!s && !p && t && m_st == 1) begin
        m_total = m_total - 1;
        if (m_total == 0) begin
          m_st   = 3;
          m_done = 1'b1;
        end
      end
    end
    sbq.push_back(predict());
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 14'd0, 0, 0, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 14'd0, 0, 0, 1);
  endtask

  task automatic do_load(input logic [2:0] a, input logic [3:0] b,
                         input logic [2:0] c, input logic [3:0] d);
    cyc(0, 1, {a, b, c, d}, 0, 0, 0);
  endtask

  task automatic do_start();
    cyc(0, 0, 14'd0, 1, 0, 0);
  endtask

  task automatic do_pause();
    cyc(0, 0, 14'd0, 0, 1, 0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Compare DUT outputs against the oldest queued prediction
  always begin : monitor
    obs_t e;
    @(posedge clk);
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("outputs",
          32'({min_tens, min_ones, sec_tens, sec_ones,
               running, done, expired}),
          32'(e));
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: time limit reached, queue %0d", sbq.size());
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    tick  = 1'b0;
    load  = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    {load_min_tens, load_min_ones, load_sec_tens, load_sec_ones} = 14'd0;

    phase = "reset";
    cyc(1, 0, 14'd0, 0, 0, 0);
    cyc(1, 0, 14'd0, 0, 0, 0);
    settle();
    chk("reset_state",
        32'({min_tens, min_ones, sec_tens, sec_ones,
             running, done, expired}), 32'd0);

    phase = "01:00";
    do_load(3'd0, 4'd1, 3'd0, 4'd0);
    do_start();
    ticks(1);
    settle();
    chk("first_tick", 32'({sec_tens, sec_ones, running}),
        32'({3'd5, 4'd9, 1'b1}));
    for (int i = 0; i < 59; i++) begin
      ticks(1);
      if (i % 7 == 0) idle_n(1);
    end
    settle();
    chk("expiry_done", 32'({done, expired, running}), 32'b110);
    idle_n(1);
    settle();
    chk("done_one_cycle", 32'({done, expired}), 32'b01);
    ticks(2);

    phase = "10:00";
    do_load(3'd1, 4'd0, 3'd0, 4'd0);
    do_start();
    ticks(1);

    phase = "00:10";
    do_load(3'd0, 4'd0, 3'd1, 4'd0);
    do_start();
    ticks(1);

    phase = "pause";
    do_load(3'd0, 4'd0, 3'd0, 4'd5);
    do_start();
    ticks(2);
    do_pause();
    ticks(3);
    settle();
    chk("paused_hold", 32'({sec_ones, running}), 32'({4'd3, 1'b0}));
    do_start();
    ticks(3);
    idle_n(2);

    phase = "clamp";
    do_load(3'd7, 4'hF, 3'd7, 4'hF);
    settle();
    chk("clamp",
        32'({min_tens, min_ones, sec_tens, sec_ones}),
        32'({3'd5, 4'd9, 3'd5, 4'd9}));
    do_start();
    ticks(3599);
    idle_n(2);

    phase = "zero_start";
    do_load(3'd0, 4'd0, 3'd0, 4'd0);
    do_start();
    ticks(3);
    do_start();
    idle_n(2);

    phase = "start_pause";
    do_load(3'd0, 4'd0, 3'd2, 4'd0);
    cyc(0, 0, 14'd0, 1, 1, 0);
    ticks(2);
    settle();
    chk("start_pause_same", 32'({running, sec_tens, sec_ones}),
        32'({1'b0, 3'd2, 4'd0}));

    phase = "tick_with_start";
    cyc(0, 0, 14'd0, 1, 0, 1);
    settle();
    chk("tick_with_start", 32'({running, sec_tens, sec_ones}),
        32'({1'b1, 3'd2, 4'd0}));
    ticks(4);
    cyc(0, 0, 14'd0, 0, 1, 1);
    ticks(1);
    cyc(0, 0, 14'd0, 1, 0, 1);
    ticks(2);

    phase = "load_in_run";
    do_load(3'd0, 4'd0, 3'd0, 4'd6);
    do_start();
    ticks(3);
    do_load(3'd0, 4'd4, 3'd3, 4'd2);
    ticks(4);
    settle();
    chk("load_in_run",
        32'({min_tens, min_ones, sec_tens, sec_ones, running}),
        32'({3'd0, 4'd4, 3'd3, 4'd2, 1'b0}));

    phase = "reset_mid";
    do_load(3'd1, 4'd2, 3'd3, 4'd4);
    do_start();
    ticks(2);
    cyc(1, 1, {3'd2, 4'd1, 3'd1, 4'd1}, 0, 0, 1);
    settle();
    chk("reset_mid",
        32'({min_tens, min_ones, sec_tens, sec_ones,
             running, done, expired}), 32'd0);
    ticks(2);
    idle_n(2);

    settle();
    settle();
    chk("queue_drained", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
